mem_access_sequencer: RTL



---
 rtl/mem_access_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: byte-wide data memory master for 8/16-bit loads/stores.
// Optional MEM_ACCESS_ALIGN_CHECK_EN rejects odd wide accesses with rsp_err.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_write/req_wide      store/load, 16/8-bit
//   req_addr/req_wdata      low-byte address, store data
//   rsp_valid/rsp_rdata     one-cycle completion pulse, load data
//   rsp_err                 misaligned wide access rejected
//   MemAdr/ReadEn/WriteEn   memory address and strobes
//   DatIn/DatOut            memory write data, memory read data
module mem_access_sequencer #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic            req_wide,
  input  logic [AW-1:0]   req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [2*DW-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [AW-1:0]   MemAdr,
  output logic            ReadEn,
  output logic            WriteEn,
  output logic [DW-1:0]   DatIn,
  input  logic [DW-1:0]   DatOut
);

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1,
    RESP
  } state_t;

  state_t          state;
  logic            wrQ;
  logic            wideQ;
  logic [AW-1:0]   addrQ;
  logic [2*DW-1:0] wdataQ;
  logic [DW-1:0]   rdLo;
  logic            readyQ;
  logic            validQ;
  logic            errQ;
  logic [2*DW-1:0] rdataQ;

  logic            memCyc;
  logic            hiByte;
  logic            strobe;
  logic            misalign;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = req_wide && req_addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign memCyc = (state == BYTE0) || (state == BYTE1);
  assign hiByte = (state == BYTE1);

  // Strobes are gated by reset so an aborted access never commits.
  assign ReadEn  = !reset && memCyc && !wrQ;
  assign WriteEn = !reset && memCyc && wrQ;
  assign strobe  = ReadEn || WriteEn;

  assign MemAdr = !strobe ? '0
                : hiByte  ? addrQ + AW'(1)
                :           addrQ;

  assign DatIn = !WriteEn ? '0
               : hiByte   ? wdataQ[2*DW-1:DW]
               :            wdataQ[DW-1:0];

  assign req_ready = readyQ;
  assign rsp_valid = validQ;
  assign rsp_rdata = rdataQ;
  assign rsp_err   = errQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wrQ    <= 1'b0;
      wideQ  <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      rdLo   <= '0;
      readyQ <= 1'b1;
      validQ <= 1'b0;
      errQ   <= 1'b0;
      rdataQ <= '0;
    end else begin
      validQ <= 1'b0;
      errQ   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && readyQ) begin
            wrQ    <= req_write;
            wideQ  <= req_wide;
            addrQ  <= req_addr;
            wdataQ <= req_wdata;
            rdLo   <= '0;
            readyQ <= 1'b0;
            if (misalign) begin
              state  <= RESP;
              validQ <= 1'b1;
              errQ   <= 1'b1;
              rdataQ <= '0;
            end else begin
              state <= BYTE0;
            end
          end
        end
        BYTE0: begin
          if (!wrQ) rdLo <= DatOut;
          if (wideQ) begin
            state <= BYTE1;
          end else begin
            state  <= RESP;
            validQ <= 1'b1;
            rdataQ <= wrQ ? '0 : {{DW{1'b0}}, DatOut};
          end
        end
        BYTE1: begin
          state  <= RESP;
          validQ <= 1'b1;
          rdataQ <= wrQ ? '0 : {DatOut, rdLo};
        end
        RESP: begin
          state  <= IDLE;
          readyQ <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          readyQ <= 1'b1;
        end
      endcase
    end
  end

endmodule
